// File: rtl/jogo_pkg.sv
// Shared definitions for the sequence-memory game: state codes, default sizes
// and the fixed sequence the player must reproduce.
package jogo_pkg;

  localparam int N_JOGADAS_PADRAO = 16;
  localparam int LARGURA_PADRAO   = 4;

  // Codes are visible on db_estado, so each value is pinned explicitly.
  typedef enum logic [3:0] {
    INICIAL    = 4'h0,
    PREPARA    = 4'h1,
    ESPERA     = 4'h2,
    REGISTRA   = 4'h4,
    COMPARA    = 4'h5,
    PROXIMA    = 4'h6,
    FIM_ACERTO = 4'hA,
    FIM_ERRO   = 4'hE
  } estado_t;

  // Entry 0 is the leftmost element, so index order matches play order.
  localparam logic [0:15][3:0] SEQUENCIA_ROM = {
    4'b0001, 4'b0010, 4'b0100, 4'b0100,
    4'b1000, 4'b0100, 4'b0010, 4'b0001,
    4'b0001, 4'b0010, 4'b0010, 4'b0100,
    4'b0100, 4'b1000, 4'b1000, 4'b0001
  };

endpackage

// File: rtl/detector_jogada.sv
// Turns the player switches into a single-cycle pulse on the 0 -> nonzero
// transition; a held value produces only one pulse.
module detector_jogada
  import jogo_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] i_chaves,
  output logic               o_tem_jogada,
  output logic               o_pulso
);

  logic r_tem_d;

  assign o_tem_jogada = |i_chaves;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_tem_d <= 1'b0;
    else        r_tem_d <= o_tem_jogada;
  end

  assign o_pulso = o_tem_jogada & ~r_tem_d;

endmodule

// File: rtl/jogo_sequencia_memoria.sv
// Responder side of the sequence-memory game: waits for each play, compares it
// against the fixed ROM sequence and reports the outcome plus debug views.
module jogo_sequencia_memoria
  import jogo_pkg::*;
#(
  parameter int N_JOGADAS = N_JOGADAS_PADRAO,
  parameter int LARGURA   = LARGURA_PADRAO
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic [LARGURA-1:0] chaves,
  output logic               acertou,
  output logic               errou,
  output logic               pronto,
  output logic [LARGURA-1:0] leds,
  output logic               db_igual,
  output logic [3:0]         db_contagem,
  output logic [LARGURA-1:0] db_memoria,
  output logic [3:0]         db_estado,
  output logic [LARGURA-1:0] db_jogadafeita,
  output logic               db_tem_jogada
);

  estado_t            r_estado;
  logic [3:0]         r_contagem;
  logic [LARGURA-1:0] r_jogada;
  logic               r_acertou;
  logic               r_errou;
  logic               r_pronto;

  logic               w_tem_jogada;
  logic               w_pulso;
  logic [LARGURA-1:0] w_memoria;
  logic               w_igual;
  logic               w_ultima;

  detector_jogada #(.LARGURA(LARGURA)) u_detector (
    .clock        (clock),
    .reset        (reset),
    .i_chaves     (chaves),
    .o_tem_jogada (w_tem_jogada),
    .o_pulso      (w_pulso)
  );

  assign w_memoria = LARGURA'(SEQUENCIA_ROM[r_contagem]);
  assign w_igual   = (r_jogada == w_memoria);
  assign w_ultima  = (r_contagem == 4'(N_JOGADAS - 1));

  // Flags are set on entry to a FIM state and cleared on leaving it, so they
  // follow the state register exactly without a decode stage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado   <= INICIAL;
      r_contagem <= '0;
      r_jogada   <= '0;
      r_acertou  <= 1'b0;
      r_errou    <= 1'b0;
      r_pronto   <= 1'b0;
    end else begin
      case (r_estado)
        INICIAL: begin
          if (iniciar) r_estado <= PREPARA;
        end
        PREPARA: begin
          r_contagem <= '0;
          r_jogada   <= '0;
          r_estado   <= ESPERA;
        end
        ESPERA: begin
          if (w_pulso) r_estado <= REGISTRA;
        end
        REGISTRA: begin
          r_jogada <= chaves;
          r_estado <= COMPARA;
        end
        COMPARA: begin
          if (w_igual && w_ultima) begin
            r_estado  <= FIM_ACERTO;
            r_acertou <= 1'b1;
            r_pronto  <= 1'b1;
          end else if (w_igual) begin
            r_estado <= PROXIMA;
          end else begin
            r_estado <= FIM_ERRO;
            r_errou  <= 1'b1;
            r_pronto <= 1'b1;
          end
        end
        PROXIMA: begin
          r_contagem <= r_contagem + 4'd1;
          r_estado   <= ESPERA;
        end
        FIM_ACERTO, FIM_ERRO: begin
          if (iniciar) begin
            r_estado  <= PREPARA;
            r_acertou <= 1'b0;
            r_errou   <= 1'b0;
            r_pronto  <= 1'b0;
          end
        end
        default: begin
          r_estado  <= INICIAL;
          r_acertou <= 1'b0;
          r_errou   <= 1'b0;
          r_pronto  <= 1'b0;
        end
      endcase
    end
  end

  assign acertou        = r_acertou;
  assign errou          = r_errou;
  assign pronto         = r_pronto;
  assign leds           = r_jogada;
  assign db_jogadafeita = r_jogada;
  assign db_igual       = w_igual;
  assign db_contagem    = r_contagem;
  assign db_memoria     = w_memoria;
  assign db_estado      = r_estado;
  assign db_tem_jogada  = w_tem_jogada;

endmodule

// File: tb/tb_jogo_sequencia_memoria.sv
// Directed bench for jogo_sequencia_memoria: drives plays on the falling edge
// and checks outputs there, against hand-computed values.
module tb_jogo_sequencia_memoria;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [3:0] chaves;
  logic       acertou, errou, pronto, db_igual, db_tem_jogada;
  logic [3:0] leds, db_contagem, db_memoria, db_estado, db_jogadafeita;

  int n_checks = 0;
  int n_fails  = 0;

  localparam logic [3:0] ROM_ESPERADA [16] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001,
    4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001
  };

  jogo_sequencia_memoria #(.N_JOGADAS(16), .LARGURA(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .iniciar        (iniciar),
    .chaves         (chaves),
    .acertou        (acertou),
    .errou          (errou),
    .pronto         (pronto),
    .leds           (leds),
    .db_igual       (db_igual),
    .db_contagem    (db_contagem),
    .db_memoria     (db_memoria),
    .db_estado      (db_estado),
    .db_jogadafeita (db_jogadafeita),
    .db_tem_jogada  (db_tem_jogada)
  );

  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic flags(input string tag, input logic a, input logic e, input logic p);
    check({tag, ".acertou"}, 8'(acertou), 8'(a));
    check({tag, ".errou"},   8'(errou),   8'(e));
    check({tag, ".pronto"},  8'(pronto),  8'(p));
  endtask

  task automatic iniciar_jogo();
    iniciar = 1'b1;
    ciclos(5);
    iniciar = 1'b0;
    ciclos(2);
  endtask

  task automatic jogar(input logic [3:0] v, input int hold);
    chaves = v;
    ciclos(hold);
    chaves = 4'b0000;
    ciclos(10);
  endtask

  initial begin
    reset   = 1'b0;
    iniciar = 1'b0;
    chaves  = 4'b0000;
    ciclos(2);
    reset = 1'b1;
    ciclos(1);

    check("rst.estado",   8'(db_estado), 8'h0);
    check("rst.contagem", 8'(db_contagem), 8'h0);
    check("rst.leds",     8'(leds), 8'h0);
    check("rst.jogada",   8'(db_jogadafeita), 8'h0);
    check("rst.memoria",  8'(db_memoria), 8'h1);
    check("rst.tem",      8'(db_tem_jogada), 8'h0);
    flags("rst", 1'b0, 1'b0, 1'b0);

    // Game 1: three correct plays, then a wrong fourth play.
    iniciar_jogo();
    check("g1.estado", 8'(db_estado), 8'h2);
    check("g1.contagem", 8'(db_contagem), 8'h0);
    jogar(4'b0001, 10);
    check("g1.cnt1", 8'(db_contagem), 8'h1);
    jogar(4'b0010, 10);
    check("g1.cnt2", 8'(db_contagem), 8'h2);
    jogar(4'b0100, 10);
    check("g1.cnt3", 8'(db_contagem), 8'h3);
    flags("g1.mid", 1'b0, 1'b0, 1'b0);

    chaves = 4'b0001;
    #1 check("lat.tem", 8'(db_tem_jogada), 8'h1);
    ciclos(1);
    check("lat.registra", 8'(db_estado), 8'h4);
    ciclos(1);
    check("lat.compara", 8'(db_estado), 8'h5);
    check("lat.leds", 8'(leds), 8'h1);
    check("lat.memoria", 8'(db_memoria), 8'h4);
    check("lat.igual", 8'(db_igual), 8'h0);
    flags("lat.compara", 1'b0, 1'b0, 1'b0);
    ciclos(1);
    check("lat.fim", 8'(db_estado), 8'hE);
    flags("lat.fim", 1'b0, 1'b1, 1'b1);
    chaves = 4'b0000;
    ciclos(10);
    check("hold.estado", 8'(db_estado), 8'hE);
    flags("hold", 1'b0, 1'b1, 1'b1);

    // Restart from FIM_ERRO with iniciar held 5 cycles.
    iniciar = 1'b1;
    ciclos(1);
    check("rs.prepara", 8'(db_estado), 8'h1);
    ciclos(1);
    check("rs.espera", 8'(db_estado), 8'h2);
    ciclos(3);
    iniciar = 1'b0;
    check("rs.espera2", 8'(db_estado), 8'h2);
    check("rs.contagem", 8'(db_contagem), 8'h0);
    check("rs.leds", 8'(leds), 8'h0);
    flags("rs", 1'b0, 1'b0, 1'b0);

    // Game 2: full correct sequence.
    for (int i = 0; i < 16; i++) begin
      jogar(ROM_ESPERADA[i], 10);
      if (i < 15) check($sformatf("full.cnt%0d", i + 1), 8'(db_contagem), 8'(i + 1));
    end
    check("full.estado", 8'(db_estado), 8'hA);
    check("full.contagem", 8'(db_contagem), 8'hF);
    check("full.igual", 8'(db_igual), 8'h1);
    flags("full", 1'b1, 1'b0, 1'b1);

    // Game 3: a held play counts once; then async reset mid-ESPERA.
    iniciar_jogo();
    check("g3.contagem", 8'(db_contagem), 8'h0);
    flags("g3", 1'b0, 1'b0, 1'b0);
    jogar(4'b0001, 20);
    check("held.contagem", 8'(db_contagem), 8'h1);
    check("held.estado", 8'(db_estado), 8'h2);
    jogar(4'b0010, 10);
    check("g3.cnt2", 8'(db_contagem), 8'h2);
    reset = 1'b0;
    #1;
    check("mrst.estado", 8'(db_estado), 8'h0);
    check("mrst.contagem", 8'(db_contagem), 8'h0);
    check("mrst.leds", 8'(leds), 8'h0);
    flags("mrst", 1'b0, 1'b0, 1'b0);
    ciclos(1);
    reset = 1'b1;
    ciclos(2);
    check("mrst.idle", 8'(db_estado), 8'h0);

    // Game 4: multi-bit play at index 0 ends in error; FIM_ERRO ignores plays.
    iniciar_jogo();
    check("g4.estado", 8'(db_estado), 8'h2);
    check("g4.contagem", 8'(db_contagem), 8'h0);
    jogar(4'b0011, 10);
    check("multi.estado", 8'(db_estado), 8'hE);
    check("multi.leds", 8'(leds), 8'h3);
    flags("multi", 1'b0, 1'b1, 1'b1);
    jogar(4'b0001, 10);
    check("ign.estado", 8'(db_estado), 8'hE);
    check("ign.leds", 8'(leds), 8'h3);
    check("ign.contagem", 8'(db_contagem), 8'h0);
    iniciar = 1'b1;
    ciclos(1);
    check("g4.prepara", 8'(db_estado), 8'h1);
    ciclos(4);
    iniciar = 1'b0;
    ciclos(1);
    check("g4.espera", 8'(db_estado), 8'h2);
    check("g4.cnt0", 8'(db_contagem), 8'h0);
    check("g4.leds", 8'(leds), 8'h0);
    flags("g4.end", 1'b0, 1'b0, 1'b0);
    jogar(4'b0001, 10);
    check("g4.cnt1", 8'(db_contagem), 8'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
